// File: rtl/banked_mem_responder.sv
// banked_mem_responder: two read ports and one write port over word-interleaved
// single-read/single-write banks. Reads have a fixed two-cycle latency. Port 1
// wins same-bank conflicts unless port 0 has lost STARVE_MAX times in a row.
module banked_mem_responder #(
  parameter int NUM_BANKS  = 16,
  parameter int BANK_DEPTH = 256,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd0_req,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_ready,
  output logic              rd0_valid,
  output logic [DATA_W-1:0] rd0_data,
  input  logic              rd1_req,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_ready,
  output logic              rd1_valid,
  output logic [DATA_W-1:0] rd1_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [1:0]        starve_cnt
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = $clog2(BANK_DEPTH);
  localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

  // Bank storage; contents are deliberately left unreset.
  logic [DATA_W-1:0] mem_q [NUM_BANKS][BANK_DEPTH];

  logic [BANK_W-1:0] bank0, bank1, bankw;
  logic [ROW_W-1:0]  row0, row1, roww;
  logic              same_bank, same_row, conflict;
  logic              acc0, acc1;
  logic [DATA_W-1:0] raw0, raw1, rdat0_d, rdat1_d;
  logic [1:0]        starve_q, starve_d;

  // Stage A: bank row sampled at the accept edge.
  logic              vld0_a_q, vld1_a_q;
  logic [DATA_W-1:0] dat0_a_q, dat1_a_q;
  // Stage B: registered response driven onto the ports.
  logic              vld0_b_q, vld1_b_q;
  logic [DATA_W-1:0] dat0_b_q, dat1_b_q;

  // Bank index comes from the low word-address bits, row from the next bits;
  // anything above bank+row aliases.
  assign bank0 = rd0_addr[BANK_W-1:0];
  assign bank1 = rd1_addr[BANK_W-1:0];
  assign bankw = wr_addr[BANK_W-1:0];
  assign row0  = rd0_addr[BANK_W +: ROW_W];
  assign row1  = rd1_addr[BANK_W +: ROW_W];
  assign roww  = wr_addr[BANK_W +: ROW_W];

  assign wr_ready = 1'b1;

  // Arbitration: only a same-bank, different-row pair of requests conflicts.
  always_comb begin
    same_bank = (bank0 == bank1);
    same_row  = (row0 == row1);
    conflict  = rd0_req && rd1_req && same_bank && !same_row;
    rd0_ready = 1'b1;
    rd1_ready = 1'b1;
    if (conflict) begin
      if (starve_q == STARVE_LIM) rd1_ready = 1'b0;
      else                        rd0_ready = 1'b0;
    end
    acc0 = rd0_req && rd0_ready;
    acc1 = rd1_req && rd1_ready;
  end

  // Starvation counter next state: clears on a port-0 accept or idle port 0,
  // counts saturating port-0 conflict losses otherwise.
  always_comb begin
    starve_d = starve_q;
    if (!rd0_req || acc0)                       starve_d = 2'd0;
    else if (conflict && starve_q != STARVE_LIM) starve_d = starve_q + 2'd1;
  end

  // Bank read data with write-first bypass; a same-bank same-row pair shares
  // port 0's bank read.
  always_comb begin
    raw0    = mem_q[bank0][row0];
    raw1    = (same_bank && same_row) ? raw0 : mem_q[bank1][row1];
    rdat0_d = (wr_req && wr_addr == rd0_addr) ? wr_data : raw0;
    rdat1_d = (wr_req && wr_addr == rd1_addr) ? wr_data : raw1;
  end

  // Bank write port; writes are always accepted.
  always_ff @(posedge clk) begin
    if (wr_req) mem_q[bankw][roww] <= wr_data;
  end

  // Two-stage response pipelines per port plus the starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 2'd0;
      vld0_a_q <= 1'b0;
      vld1_a_q <= 1'b0;
      dat0_a_q <= '0;
      dat1_a_q <= '0;
      vld0_b_q <= 1'b0;
      vld1_b_q <= 1'b0;
      dat0_b_q <= '0;
      dat1_b_q <= '0;
    end else begin
      starve_q <= starve_d;
      vld0_a_q <= acc0;
      vld1_a_q <= acc1;
      if (acc0) dat0_a_q <= rdat0_d;
      if (acc1) dat1_a_q <= rdat1_d;
      vld0_b_q <= vld0_a_q;
      vld1_b_q <= vld1_a_q;
      if (vld0_a_q) dat0_b_q <= dat0_a_q;
      if (vld1_a_q) dat1_b_q <= dat1_a_q;
    end
  end

  assign rd0_valid  = vld0_b_q;
  assign rd1_valid  = vld1_b_q;
  assign rd0_data   = dat0_b_q;
  assign rd1_data   = dat1_b_q;
  assign starve_cnt = starve_q;

endmodule

// File: tb/tb_banked_mem_responder.sv
// Directed testbench for banked_mem_responder.
module tb_banked_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd0_req, rd1_req, wr_req;
  logic [14:0] rd0_addr, rd1_addr, wr_addr;
  logic [15:0] wr_data;
  logic        rd0_ready, rd1_ready, rd0_valid, rd1_valid, wr_ready;
  logic [15:0] rd0_data, rd1_data;
  logic [1:0]  starve_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  banked_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_ready(rd0_ready),
    .rd0_valid(rd0_valid), .rd0_data(rd0_data),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_ready(rd1_ready),
    .rd1_valid(rd1_valid), .rd1_data(rd1_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [14:0] a, input logic [15:0] d);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++; if (rd0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd0_valid: got %b, expected 0", rd0_valid); end
    n_checks++; if (rd1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd1_valid: got %b, expected 0", rd1_valid); end
    n_checks++; if (rd0_data !== 16'h0) begin n_fail++; $display("FAIL reset_rd0_data: got %h, expected 0000", rd0_data); end
    n_checks++; if (rd1_data !== 16'h0) begin n_fail++; $display("FAIL reset_rd1_data: got %h, expected 0000", rd1_data); end
    n_checks++; if (starve_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_starve: got %0d, expected 0", starve_cnt); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b, expected 1", wr_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    wr_word(15'h0005, 16'h1234);
    rd1_req = 1'b1; rd1_addr = 15'h0005;
    #1;
    n_checks++; if (rd1_ready !== 1'b1) begin n_fail++; $display("FAIL wr_rd_ready: got %b, expected 1", rd1_ready); end
    tick();
    rd1_req = 1'b0;
    n_checks++; if (rd1_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_early_valid: got %b, expected 0", rd1_valid); end
    tick();
    n_checks++; if (rd1_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rd_valid: got %b, expected 1", rd1_valid); end
    n_checks++; if (rd1_data !== 16'h1234) begin n_fail++; $display("FAIL wr_rd_data: got %h, expected 1234", rd1_data); end
    n_checks++; if (rd0_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_idle_rd0: got %b, expected 0", rd0_valid); end
    tick();
    n_checks++; if (rd1_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_one_pulse: got %b, expected 0", rd1_valid); end
  endtask

  task automatic test_diff_banks();
    wr_word(15'h0003, 16'hA003);
    wr_word(15'h0014, 16'hB014);
    rd0_req = 1'b1; rd0_addr = 15'h0003;
    rd1_req = 1'b1; rd1_addr = 15'h0014;
    #1;
    n_checks++; if (rd0_ready !== 1'b1) begin n_fail++; $display("FAIL diff_rd0_ready: got %b, expected 1", rd0_ready); end
    n_checks++; if (rd1_ready !== 1'b1) begin n_fail++; $display("FAIL diff_rd1_ready: got %b, expected 1", rd1_ready); end
    tick();
    rd0_req = 1'b0; rd1_req = 1'b0;
    tick();
    n_checks++; if (rd0_valid !== 1'b1 || rd0_data !== 16'hA003) begin n_fail++; $display("FAIL diff_rd0_resp: got v=%b d=%h, expected v=1 d=a003", rd0_valid, rd0_data); end
    n_checks++; if (rd1_valid !== 1'b1 || rd1_data !== 16'hB014) begin n_fail++; $display("FAIL diff_rd1_resp: got v=%b d=%h, expected v=1 d=b014", rd1_valid, rd1_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    rd1_req = 1'b1; rd1_addr = 15'h0003;
    tick();
    rd1_addr = 15'h0014;
    tick();
    rd1_req = 1'b0;
    n_checks++; if (rd1_valid !== 1'b1 || rd1_data !== 16'hA003) begin n_fail++; $display("FAIL b2b_first: got v=%b d=%h, expected v=1 d=a003", rd1_valid, rd1_data); end
    tick();
    n_checks++; if (rd1_valid !== 1'b1 || rd1_data !== 16'hB014) begin n_fail++; $display("FAIL b2b_second: got v=%b d=%h, expected v=1 d=b014", rd1_valid, rd1_data); end
    tick();
    n_checks++; if (rd1_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b, expected 0", rd1_valid); end
  endtask

  task automatic test_conflict();
    wr_word(15'h0002, 16'h2222);
    wr_word(15'h0012, 16'h1212);
    rd0_req = 1'b1; rd0_addr = 15'h0002;
    rd1_req = 1'b1; rd1_addr = 15'h0012;
    #1;
    n_checks++; if (rd0_ready !== 1'b0 || rd1_ready !== 1'b1) begin n_fail++; $display("FAIL cf_c1_ready: got r0=%b r1=%b, expected r0=0 r1=1", rd0_ready, rd1_ready); end
    n_checks++; if (starve_cnt !== 2'd0) begin n_fail++; $display("FAIL cf_c1_starve: got %0d, expected 0", starve_cnt); end
    tick();
    n_checks++; if (rd0_ready !== 1'b0 || rd1_ready !== 1'b1) begin n_fail++; $display("FAIL cf_c2_ready: got r0=%b r1=%b, expected r0=0 r1=1", rd0_ready, rd1_ready); end
    n_checks++; if (starve_cnt !== 2'd1) begin n_fail++; $display("FAIL cf_c2_starve: got %0d, expected 1", starve_cnt); end
    tick();
    n_checks++; if (rd0_ready !== 1'b1 || rd1_ready !== 1'b0) begin n_fail++; $display("FAIL cf_c3_ready: got r0=%b r1=%b, expected r0=1 r1=0", rd0_ready, rd1_ready); end
    n_checks++; if (starve_cnt !== 2'd2) begin n_fail++; $display("FAIL cf_c3_starve: got %0d, expected 2", starve_cnt); end
    n_checks++; if (rd1_valid !== 1'b1 || rd1_data !== 16'h1212) begin n_fail++; $display("FAIL cf_c3_rd1_resp: got v=%b d=%h, expected v=1 d=1212", rd1_valid, rd1_data); end
    tick();
    rd0_req = 1'b0;
    #1;
    n_checks++; if (starve_cnt !== 2'd0) begin n_fail++; $display("FAIL cf_c4_starve: got %0d, expected 0", starve_cnt); end
    n_checks++; if (rd1_ready !== 1'b1) begin n_fail++; $display("FAIL cf_c4_rd1_ready: got %b, expected 1", rd1_ready); end
    n_checks++; if (rd1_valid !== 1'b1) begin n_fail++; $display("FAIL cf_c4_rd1_valid: got %b, expected 1", rd1_valid); end
    tick();
    rd1_req = 1'b0;
    n_checks++; if (rd0_valid !== 1'b1 || rd0_data !== 16'h2222) begin n_fail++; $display("FAIL cf_c5_rd0_resp: got v=%b d=%h, expected v=1 d=2222", rd0_valid, rd0_data); end
    n_checks++; if (rd1_valid !== 1'b0) begin n_fail++; $display("FAIL cf_c5_rd1_gap: got %b, expected 0", rd1_valid); end
    tick();
    n_checks++; if (rd1_valid !== 1'b1 || rd1_data !== 16'h1212 || rd0_valid !== 1'b0) begin n_fail++; $display("FAIL cf_c6_resp: got v1=%b d1=%h v0=%b, expected v1=1 d1=1212 v0=0", rd1_valid, rd1_data, rd0_valid); end
    tick();
  endtask

  task automatic test_bypass();
    wr_word(15'h0007, 16'h0000);
    rd0_req = 1'b1; rd0_addr = 15'h0007;
    tick();
    wr_req = 1'b1; wr_addr = 15'h0007; wr_data = 16'hBEEF;
    tick();
    wr_req = 1'b0; rd0_req = 1'b0;
    n_checks++; if (rd0_valid !== 1'b1 || rd0_data !== 16'h0000) begin n_fail++; $display("FAIL byp_old: got v=%b d=%h, expected v=1 d=0000", rd0_valid, rd0_data); end
    tick();
    n_checks++; if (rd0_valid !== 1'b1 || rd0_data !== 16'hBEEF) begin n_fail++; $display("FAIL byp_new: got v=%b d=%h, expected v=1 d=beef", rd0_valid, rd0_data); end
    tick();
  endtask

  task automatic test_same_addr();
    wr_word(15'h0009, 16'h5A5A);
    rd0_req = 1'b1; rd0_addr = 15'h0009;
    rd1_req = 1'b1; rd1_addr = 15'h0009;
    #1;
    n_checks++; if (rd0_ready !== 1'b1 || rd1_ready !== 1'b1) begin n_fail++; $display("FAIL same_ready: got r0=%b r1=%b, expected 1 1", rd0_ready, rd1_ready); end
    tick();
    rd0_req = 1'b0; rd1_req = 1'b0;
    tick();
    n_checks++; if (rd0_valid !== 1'b1 || rd0_data !== 16'h5A5A) begin n_fail++; $display("FAIL same_rd0: got v=%b d=%h, expected v=1 d=5a5a", rd0_valid, rd0_data); end
    n_checks++; if (rd1_valid !== 1'b1 || rd1_data !== 16'h5A5A) begin n_fail++; $display("FAIL same_rd1: got v=%b d=%h, expected v=1 d=5a5a", rd1_valid, rd1_data); end
    tick();
  endtask

  task automatic test_alias();
    wr_word(15'h7005, 16'h7777);
    rd1_req = 1'b1; rd1_addr = 15'h0005;
    tick();
    rd1_req = 1'b0;
    tick();
    n_checks++; if (rd1_valid !== 1'b1 || rd1_data !== 16'h7777) begin n_fail++; $display("FAIL alias: got v=%b d=%h, expected v=1 d=7777", rd1_valid, rd1_data); end
    tick();
  endtask

  task automatic test_reset_midflight();
    wr_word(15'h0001, 16'h0101);
    rd1_req = 1'b1; rd1_addr = 15'h0001;
    tick();
    rd1_req = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (rd1_valid !== 1'b0 || rd0_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got v0=%b v1=%b, expected 0 0", rd0_valid, rd1_valid); end
    n_checks++; if (rd0_data !== 16'h0 || rd1_data !== 16'h0 || starve_cnt !== 2'd0) begin n_fail++; $display("FAIL rst_mid_outs: got d0=%h d1=%h s=%0d, expected 0 0 0", rd0_data, rd1_data, starve_cnt); end
    tick();
    n_checks++; if (rd1_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dropped: got %b, expected 0", rd1_valid); end
    rst_n = 1'b1;
    rd0_req = 1'b1; rd0_addr = 15'h0001;
    #1;
    n_checks++; if (rd0_ready !== 1'b1) begin n_fail++; $display("FAIL rst_post_ready: got %b, expected 1", rd0_ready); end
    tick();
    rd0_req = 1'b0;
    n_checks++; if (rd1_valid !== 1'b0) begin n_fail++; $display("FAIL rst_post_rd1: got %b, expected 0", rd1_valid); end
    tick();
    n_checks++; if (rd0_valid !== 1'b1 || rd0_data !== 16'h0101) begin n_fail++; $display("FAIL rst_post_resp: got v=%b d=%h, expected v=1 d=0101", rd0_valid, rd0_data); end
    tick();
  endtask

  initial begin
    rst_n = 1'b1;
    rd0_req = 1'b0; rd1_req = 1'b0; wr_req = 1'b0;
    rd0_addr = '0; rd1_addr = '0; wr_addr = '0; wr_data = '0;
    #2 rst_n = 1'b0;
    test_reset();
    test_write_read();
    test_diff_banks();
    test_back_to_back();
    test_conflict();
    test_bypass();
    test_same_addr();
    test_alias();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
